wishbone_master: RTL and testbench

WISHBONE_MASTER -- requirements
Module: wishbone_master

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_timeout.sv | 39 +++
 rtl/wishbone_master.sv | 139 +++++++++++++
 tb/tb_wishbone_master.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and default widths for the Wishbone master slice.
package wb_pkg;

    localparam int unsigned WB_DEFAULT_WIDTH      = 8;
    localparam int unsigned WB_DEFAULT_ADDR_LINES = 16;
    localparam int unsigned WB_DEFAULT_TIMEOUT    = 255;
    localparam int unsigned WB_TIMEOUT_BITS       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } wb_state_e;

endpackage : wb_pkg

// File: rtl/wb_timeout.sv
// Bus-cycle watchdog: counts enabled cycles since clear, flags the last allowed one.
module wb_timeout
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = WB_DEFAULT_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [WB_TIMEOUT_BITS-1:0] LAST_CNT = WB_TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

    logic [WB_TIMEOUT_BITS-1:0] count_q;
    logic [WB_TIMEOUT_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != LAST_CNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires during the TIMEOUT_CYCLES-th busy cycle so the abort lands right after it.
    assign o_expired = i_enable && !i_clear && (count_q == LAST_CNT);

endmodule : wb_timeout

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone pipelined master (IDLE -> ISSUE -> WAIT -> RESP).
// Optional bus timeout abort enabled by defining WB_MASTER_TIMEOUT_EN.
module wishbone_master
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH          = WB_DEFAULT_WIDTH,
    parameter int unsigned ADDR_LINES     = WB_DEFAULT_ADDR_LINES,
    parameter int unsigned TIMEOUT_CYCLES = WB_DEFAULT_TIMEOUT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_LINES-1:0] i_req_addr,
    input  logic [WIDTH-1:0]      i_req_data,
    output logic                  o_rsp_valid,
    output logic [WIDTH-1:0]      o_rsp_data,
    output logic                  o_rsp_err,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_LINES-1:0] o_wb_addr,
    output logic [WIDTH-1:0]      o_wb_data,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_stall,
    input  logic [WIDTH-1:0]      i_wb_data
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("wishbone_master: TIMEOUT_CYCLES must be within 1..65535");
    end

    wb_state_e             state_q;
    logic                  cyc_q;
    logic                  stb_q;
    logic                  we_q;
    logic [ADDR_LINES-1:0] addr_q;
    logic [WIDTH-1:0]      data_q;
    logic                  rsp_valid_q;
    logic [WIDTH-1:0]      rsp_data_q;
    logic                  rsp_err_q;

    logic accept;
    logic busy;
    logic tmo_expired;

    assign accept = (state_q == ST_IDLE) && i_req_valid;
    assign busy   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

`ifdef WB_MASTER_TIMEOUT_EN
    wb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (accept),
        .i_enable  (busy),
        .o_expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q    <= i_req_we;
                        addr_q  <= i_req_addr;
                        data_q  <= i_req_data;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Ack is meaningless until the strobe has been taken; only stall matters here.
                    if (tmo_expired) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (!i_wb_stall) begin
                        stb_q   <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_wb_ack) begin
                        cyc_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= we_q ? '0 : i_wb_data;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_RESP;
                    end else if (tmo_expired) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_wb_we     = we_q;
    assign o_wb_addr   = addr_q;
    assign o_wb_data   = data_q;

endmodule : wishbone_master

// File: tb/tb_wishbone_master.sv
// Scoreboard bench for wishbone_master: memory slave model plus response monitor.
module tb_wishbone_master;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_we;
    logic [15:0] i_req_addr;
    logic [7:0]  i_req_data;
    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic [7:0]  o_rsp_data;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [15:0] o_wb_addr;
    logic [7:0]  o_wb_data;
    logic        i_wb_ack, i_wb_stall;
    logic [7:0]  i_wb_data;

    wishbone_master #(
        .WIDTH(8),
        .ADDR_LINES(16),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    logic [7:0] mem [logic [15:0]];
    logic [7:0] ref_mem [logic [15:0]];

    int          cfg_stall = 0, cfg_ackd = 0;
    bit          cfg_noack = 0, cfg_spur = 0, cfg_idle_ack = 0;
    logic        cur_we = 1'b0;
    logic [15:0] cur_addr = '0;
    logic [7:0]  cur_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    // Slave: programmable stall length and ack delay, backed by mem.
    initial begin
        int stall_left, wait_left, stb_seen;
        bit in_wait;
        stall_left = 0; wait_left = 0; stb_seen = 0; in_wait = 0;
        i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = '0;
        forever begin
            @(negedge clk);
            i_wb_ack  = 1'b0;
            i_wb_data = 8'($urandom);
            if (rst) begin
                stb_seen = 0; in_wait = 0; i_wb_stall = 1'b0;
                continue;
            end
            if (o_wb_cyc && o_wb_stb) begin
                if (stb_seen == 0) stall_left = cfg_stall;
                stb_seen++;
                check("bus_we", o_wb_we, cur_we);
                check("bus_addr", o_wb_addr, cur_addr);
                check("bus_data", o_wb_data, cur_data);
                if (stall_left > 0) begin
                    stall_left--;
                    i_wb_stall = 1'b1;
                    i_wb_ack   = cfg_spur;
                end else begin
                    i_wb_stall = 1'b0;
                    check("stb_cycles", stb_seen, cfg_stall + 1);
                    stb_seen  = 0;
                    in_wait   = 1;
                    wait_left = cfg_ackd;
                end
            end else begin
                i_wb_stall = 1'($urandom_range(0, 1));
                if (!o_wb_cyc) begin
                    in_wait  = 0;
                    stb_seen = 0;
                    i_wb_ack = cfg_idle_ack;
                end else if (in_wait) begin
                    check("stb_low_in_wait", o_wb_stb, 0);
                    if (wait_left == 0 && !cfg_noack) begin
                        i_wb_ack = 1'b1;
                        in_wait  = 0;
                        if (cur_we) mem[cur_addr] = cur_data;
                        else i_wb_data = mem.exists(cur_addr) ? mem[cur_addr] : 8'h00;
                    end else if (wait_left > 0) begin
                        wait_left--;
                    end
                end
            end
        end
    end

    // Monitor: every response pulse must match the oldest scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp_valid", o_rsp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_data", o_rsp_data, e.data);
                    check("rsp_err", o_rsp_err, e.err);
                    check("rsp_cycle", cyc_n, e.cyc);
                    check("cyc_low_in_resp", o_wb_cyc, 0);
                    check("ready_low_in_resp", o_req_ready, 0);
                end
            end else if (sb.size() > 0 && cyc_n > sb[0].cyc) begin
                check("rsp_missing", o_rsp_valid, 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic we, input logic [15:0] a, input logic [7:0] d,
                         input int stall, input int ackd, input bit noack,
                         input bit expect_rsp, output int acc);
        int guard;
        exp_t e;
        guard = 0;
        acc = -1;
        @(negedge clk);
        while (!o_req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!o_req_ready) begin
            check("req_ready_wait", o_req_ready, 1);
            return;
        end
        cfg_stall = stall; cfg_ackd = ackd; cfg_noack = noack;
        cur_we = we; cur_addr = a; cur_data = d;
        i_req_valid = 1'b1; i_req_we = we; i_req_addr = a; i_req_data = d;
        acc = cyc_n;
        e.err = noack;
        if (noack) begin
            e.data = 8'h00;
            e.cyc  = acc + 1 + TMO;
        end else begin
            e.data = we ? 8'h00 : (ref_mem.exists(a) ? ref_mem[a] : 8'h00);
            e.cyc  = acc + 3 + stall + ackd;
            if (we) ref_mem[a] = d;
        end
        if (expect_rsp) sb.push_back(e);
        @(negedge clk);
        i_req_valid = 1'b0;
        i_req_we    = 1'($urandom_range(0, 1));
        i_req_addr  = 16'($urandom);
        i_req_data  = 8'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || !o_req_ready) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n1, n2;
        rst = 1'b1;
        i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0; i_req_data = '0;
        mem[16'h0010]     = 8'h5A;
        ref_mem[16'h0010] = 8'h5A;

        repeat (3) @(negedge clk);
        check("rst_cyc", o_wb_cyc, 0);
        check("rst_stb", o_wb_stb, 0);
        check("rst_we", o_wb_we, 0);
        check("rst_addr", o_wb_addr, 0);
        check("rst_data", o_wb_data, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_err", o_rsp_err, 0);
        check("rst_rsp_data", o_rsp_data, 0);
        check("rst_ready", o_req_ready, 1);
        rst = 1'b0;

        // Directed write, read, stalled read, back-to-back throughput.
        issue(1'b1, 16'h1234, 8'hA5, 0, 0, 0, 1, n1);
        drain();
        issue(1'b0, 16'h0010, 8'h00, 0, 0, 0, 1, n1);
        drain();
        issue(1'b0, 16'h1234, 8'h3C, 3, 0, 0, 1, n1);
        drain();
        issue(1'b1, 16'h0020, 8'h11, 0, 0, 0, 1, n1);
        issue(1'b0, 16'h0020, 8'h00, 0, 0, 0, 1, n2);
        check("throughput", n2 - n1, 4);
        drain();

        // Ack and timeout land in the same cycle: ack wins.
        issue(1'b0, 16'h0010, 8'h00, 3, 3, 0, 1, n1);
        drain();

        // Spurious ack in IDLE, then during stalled ISSUE.
        cfg_idle_ack = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_ack_ready", o_req_ready, 1);
            check("idle_ack_cyc", o_wb_cyc, 0);
        end
        cfg_idle_ack = 1'b0;
        cfg_spur = 1'b1;
        issue(1'b0, 16'h0010, 8'h00, 2, 1, 0, 1, n1);
        drain();
        cfg_spur = 1'b0;

`ifdef WB_MASTER_TIMEOUT_EN
        issue(1'b0, 16'h0010, 8'h00, 0, 0, 1, 1, n1);
        drain();
        issue(1'b1, 16'h0030, 8'h77, 0, 0, 1, 1, n1);
        drain();
        issue(1'b0, 16'h0010, 8'h00, 1, 0, 0, 1, n1);
        drain();
`endif

        // Reset while waiting for ack: transaction abandoned, no response.
        issue(1'b0, 16'h0010, 8'h00, 0, 20, 0, 0, n1);
        @(negedge clk);
        check("in_wait_cyc", o_wb_cyc, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_cyc", o_wb_cyc, 0);
        check("rst_mid_stb", o_wb_stb, 0);
        check("rst_mid_rsp_valid", o_rsp_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", o_req_ready, 1);
        repeat (4) @(negedge clk);

        // Randomized traffic over a small address window.
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 8'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 1, n1);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wishbone_master
